// File: rtl/psram_arb_nch.sv
// N-channel round-robin / strict-priority arbiter in front of the PSRAM HS command port.
// Grant and command are registered one cycle after the request; read data is routed combinationally to the owning channel.
module psram_arb_nch #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 64,
  parameter int MASK_W     = DATA_W / 8,
  parameter int BEATS      = 4,
  parameter int TCMD       = 19,
  parameter int HIPRI_EN   = 1,
  parameter int HIPRI_CH   = 0,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH-1:0]        i_we,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_wdata,
  input  logic [NUM_CH*MASK_W-1:0] i_mask,
  output logic [NUM_CH-1:0]        o_gnt,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [NUM_CH-1:0]        o_rvalid,
  output logic                     o_busy,
  output logic                     o_timeout_err,
  output logic                     o_psram_cmd,
  output logic                     o_psram_cmd_en,
  output logic [ADDR_W-1:0]        o_psram_addr,
  output logic [DATA_W-1:0]        o_psram_wr_data,
  output logic [MASK_W-1:0]        o_psram_data_mask,
  input  logic [DATA_W-1:0]        i_psram_rd_data,
  input  logic                     i_psram_rd_data_valid,
  input  logic                     i_psram_init_calib
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW   = $clog2(TCMD + 1);
  localparam int BW   = $clog2(BEATS + 1);
  localparam int TW   = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, GAP} state_t;

  state_t            state;
  logic [CH_W-1:0]   own;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   win;
  logic              win_vld;
  logic              win_rr;
  logic [IW-1:0]     gap_cnt;
  logic [BW-1:0]     beat_cnt;
  logic [TW-1:0]     to_cnt;
  logic [DATA_W-1:0] wdata_hold;
  logic [MASK_W-1:0] mask_hold;
  logic              rd_beat;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [MASK_W-1:0] mask_a  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign addr_a[c]  = i_addr[c*ADDR_W +: ADDR_W];
    assign wdata_a[c] = i_wdata[c*DATA_W +: DATA_W];
    assign mask_a[c]  = i_mask[c*MASK_W +: MASK_W];
  end

  // Scan downward so the last hit is the nearest channel above last_grant.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    win_rr  = 1'b0;
    if (HIPRI_EN != 0 && i_req[HIPRI_CH]) begin
      win     = CH_W'(HIPRI_CH);
      win_vld = 1'b1;
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        if (i_req[CH_W'((int'(last_grant) + k) % NUM_CH)]) begin
          win     = CH_W'((int'(last_grant) + k) % NUM_CH);
          win_vld = 1'b1;
          win_rr  = 1'b1;
        end
      end
    end
  end

  // Write beats follow the client bus live so it can advance on each grant cycle.
  assign o_psram_wr_data   = (state == WRITE) ? wdata_a[own] : wdata_hold;
  assign o_psram_data_mask = (state == WRITE) ? mask_a[own]  : mask_hold;

  assign rd_beat  = (state == READ) && i_psram_rd_data_valid;
  assign o_rvalid = rd_beat ? (NUM_CH'(1) << own) : '0;
  assign o_rdata  = rd_beat ? i_psram_rd_data : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= INIT;
      own            <= '0;
      last_grant     <= CH_W'(NUM_CH - 1);
      gap_cnt        <= '0;
      beat_cnt       <= '0;
      to_cnt         <= '0;
      wdata_hold     <= '0;
      mask_hold      <= '0;
      o_gnt          <= '0;
      o_busy         <= 1'b0;
      o_timeout_err  <= 1'b0;
      o_psram_cmd    <= 1'b0;
      o_psram_cmd_en <= 1'b0;
      o_psram_addr   <= '0;
    end else begin
      o_psram_cmd_en <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      case (state)
        INIT: begin
          if (i_psram_init_calib) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            o_busy <= 1'b1;
          end
        end

        IDLE: begin
          if (win_vld && gap_cnt == '0) begin
            own            <= win;
            if (win_rr) last_grant <= win;
            o_psram_cmd_en <= 1'b1;
            o_psram_cmd    <= i_we[win];
            o_psram_addr   <= addr_a[win];
            o_gnt          <= NUM_CH'(1) << win;
            gap_cnt        <= IW'(TCMD - 1);
            beat_cnt       <= '0;
            to_cnt         <= '0;
            o_busy         <= 1'b1;
            state          <= i_we[win] ? WRITE : READ;
          end
        end

        WRITE: begin
          wdata_hold <= wdata_a[own];
          mask_hold  <= mask_a[own];
          if (beat_cnt == BW'(BEATS - 1)) begin
            o_gnt <= '0;
            state <= GAP;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        READ: begin
          o_gnt  <= '0;
          to_cnt <= to_cnt + 1'b1;
          if (i_psram_rd_data_valid) beat_cnt <= beat_cnt + 1'b1;
          // A final beat arriving on the timeout cycle still counts as completion.
          if (i_psram_rd_data_valid && beat_cnt == BW'(BEATS - 1)) begin
            state <= GAP;
          end else if (to_cnt == TW'(RD_TIMEOUT - 1)) begin
            o_timeout_err <= 1'b1;
            state         <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule
